// File: rtl/csr_file_pkg.sv
// Shared CSR addresses, mstatus bit positions and alignment mask for the machine-mode CSR file.
package csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [31:0] ALIGN4_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v = '0;
    v[MSTATUS_MIE]  = mie;
    v[MSTATUS_MPIE] = mpie;
    return v;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half overwrite; a write to either half freezes the count that cycle.
// Only built when CSR_COUNTERS_EN is defined.
`ifdef CSR_COUNTERS_EN
module csr_counter64 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (wr_lo || wr_hi) begin
      // Halves are written independently; no carry between them on a write.
      if (wr_lo) cnt[31:0]  <= wdata;
      if (wr_hi) cnt[63:32] <= wdata;
    end else if (inc) begin
      cnt <= cnt + 64'd1;
    end
  end

  assign value = cnt;

endmodule
`endif

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap state, combinational read port, optional 64-bit cycle/instret counters.
// Counters are present only when CSR_COUNTERS_EN is defined; otherwise their addresses read 0.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [11:0] r_addr,
  output logic [31:0] r_data,
  input  logic        csr_w_enabled,
  input  logic [11:0] csr_w_addr,
  input  logic [31:0] csr_w_data,
  input  logic        instr_retired,
  input  logic        trap,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  output logic [31:0] trap_vector,
  output logic [31:0] epc,
  output logic        irq_enabled
);

  logic        mie, mpie;
  logic [31:0] mtvec, mepc, mcause, mscratch;

  // Trap beats mret beats a software write; a dropped write has no side effects.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET & ALIGN4_MASK;
      mepc     <= '0;
      mcause   <= '0;
      mscratch <= '0;
    end else if (trap) begin
      mepc   <= trap_pc & ALIGN4_MASK;
      mcause <= trap_cause;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (mret) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (csr_w_enabled) begin
      case (csr_w_addr)
        CSR_MSTATUS: begin
          mie  <= csr_w_data[MSTATUS_MIE];
          mpie <= csr_w_data[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec    <= csr_w_data & ALIGN4_MASK;
        CSR_MSCRATCH: mscratch <= csr_w_data;
        CSR_MEPC:     mepc     <= csr_w_data & ALIGN4_MASK;
        CSR_MCAUSE:   mcause   <= csr_w_data;
        default: ;
      endcase
    end
  end

  assign trap_vector = mtvec;
  assign epc         = mepc;
  assign irq_enabled = mie;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;

  // Counter writes are independent of trap/mret; only the M-mode addresses are writable.
  csr_counter64 u_mcycle (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (1'b1),
    .wr_lo (csr_w_enabled && (csr_w_addr == CSR_MCYCLE)),
    .wr_hi (csr_w_enabled && (csr_w_addr == CSR_MCYCLEH)),
    .wdata (csr_w_data),
    .value (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (instr_retired),
    .wr_lo (csr_w_enabled && (csr_w_addr == CSR_MINSTRET)),
    .wr_hi (csr_w_enabled && (csr_w_addr == CSR_MINSTRETH)),
    .wdata (csr_w_data),
    .value (minstret)
  );
`else
  logic unused_instr_retired;
  assign unused_instr_retired = instr_retired;
`endif

  always_comb begin
    r_data = '0;
    case (r_addr)
      CSR_MSTATUS:  r_data = mstatus_pack(mie, mpie);
      CSR_MTVEC:    r_data = mtvec;
      CSR_MSCRATCH: r_data = mscratch;
      CSR_MEPC:     r_data = mepc;
      CSR_MCAUSE:   r_data = mcause;
      CSR_MHARTID:  r_data = '0;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,    CSR_CYCLE:    r_data = mcycle[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   r_data = mcycle[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  r_data = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: r_data = minstret[63:32];
`else
      CSR_MCYCLE, CSR_CYCLE, CSR_MCYCLEH, CSR_CYCLEH,
      CSR_MINSTRET, CSR_INSTRET, CSR_MINSTRETH, CSR_INSTRETH: r_data = '0;
`endif
      default: r_data = '0;
    endcase
  end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: reset state, write/readback table, trap/mret priority, counters, async reset.
// Counter scenarios follow CSR_COUNTERS_EN; without it counter addresses are checked to read 0.
module tb_csr_file;

  localparam logic [31:0] RST_VEC = 32'h8000_0100;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] r_addr;
  logic [31:0] r_data;
  logic        csr_w_enabled;
  logic [11:0] csr_w_addr;
  logic [31:0] csr_w_data;
  logic        instr_retired;
  logic        trap;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret;
  logic [31:0] trap_vector;
  logic [31:0] epc;
  logic        irq_enabled;

  always #5 clk = ~clk;

  csr_file #(.MTVEC_RESET(RST_VEC)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .r_addr        (r_addr),
    .r_data        (r_data),
    .csr_w_enabled (csr_w_enabled),
    .csr_w_addr    (csr_w_addr),
    .csr_w_data    (csr_w_data),
    .instr_retired (instr_retired),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .trap_pc       (trap_pc),
    .mret          (mret),
    .trap_vector   (trap_vector),
    .epc           (epc),
    .irq_enabled   (irq_enabled)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] old_v;
    logic [31:0] new_v;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, got, exp);
  endtask

  // Expected value is queued with the stimulus and retired when r_data is sampled.
  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    r_addr = a;
    #1;
    e = exp_q.pop_front();
    check(name, r_data, e);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_w_enabled = 1'b1;
    csr_w_addr    = a;
    csr_w_data    = d;
    @(negedge clk);
    csr_w_enabled = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{12'h340, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
    vecs[1] = '{12'h305, 32'h0000_1003, RST_VEC,       32'h0000_1000};
    vecs[2] = '{12'h300, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0088};
    vecs[3] = '{12'h300, 32'h0000_0008, 32'h0000_0088, 32'h0000_0008};
    vecs[4] = '{12'h341, 32'h0000_3007, 32'h0000_0000, 32'h0000_3004};
    vecs[5] = '{12'h342, 32'h8000_0007, 32'h0000_0000, 32'h8000_0007};
    vecs[6] = '{12'h7C0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{12'hF14, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000};

    rstn = 1'b1;
    csr_w_enabled = 1'b0; csr_w_addr = '0; csr_w_data = '0;
    instr_retired = 1'b0; trap = 1'b0; mret = 1'b0;
    trap_cause = '0; trap_pc = '0; r_addr = '0;
    #1 rstn = 1'b0;
    #1;
    check("rst_trap_vector", trap_vector, RST_VEC);
    check("rst_epc", epc, 32'h0);
    check("rst_irq", {31'h0, irq_enabled}, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0);
    rd("rst_mtvec", 12'h305, RST_VEC);

    @(negedge clk);
    rstn = 1'b1;
`ifdef CSR_COUNTERS_EN
    rd("mcycle_0", 12'hB00, 32'd0);
    @(negedge clk);
    rd("mcycle_1", 12'hB00, 32'd1);
    @(negedge clk);
    rd("mcycle_2", 12'hB00, 32'd2);
    for (int k = 0; k < 3; k++) begin
      instr_retired = 1'b1;
      @(negedge clk);
      instr_retired = 1'b0;
      @(negedge clk);
    end
    rd("minstret_3", 12'hB02, 32'd3);
    rd("instret_alias", 12'hC02, 32'd3);
    rd("minstreth_0", 12'hB82, 32'd0);
    instr_retired = 1'b1;
    wr(12'hB02, 32'd10);
    instr_retired = 1'b0;
    rd("minstret_wr_suppress", 12'hB02, 32'd10);
`else
    @(negedge clk);
    @(negedge clk);
    rd("nocnt_mcycle", 12'hB00, 32'h0);
    rd("nocnt_cycle", 12'hC00, 32'h0);
    rd("nocnt_mcycleh", 12'hB80, 32'h0);
    wr(12'hB00, 32'h0000_0005);
    rd("nocnt_mcycle_wr", 12'hB00, 32'h0);
`endif

    for (int i = 0; i < 8; i++) begin
      csr_w_enabled = 1'b1;
      csr_w_addr    = vecs[i].addr;
      csr_w_data    = vecs[i].wdata;
      rd($sformatf("vec%0d_old", i), vecs[i].addr, vecs[i].old_v);
      @(negedge clk);
      csr_w_enabled = 1'b0;
      rd($sformatf("vec%0d_new", i), vecs[i].addr, vecs[i].new_v);
    end
    check("tbl_trap_vector", trap_vector, 32'h0000_1000);
    check("tbl_epc", epc, 32'h0000_3004);
    check("tbl_irq", {31'h0, irq_enabled}, 32'h1);

    trap = 1'b1; trap_cause = 32'h0000_000B; trap_pc = 32'h0000_2006;
    @(negedge clk);
    trap = 1'b0;
    rd("trap_mepc", 12'h341, 32'h0000_2004);
    rd("trap_mcause", 12'h342, 32'h0000_000B);
    rd("trap_mstatus", 12'h300, 32'h0000_0080);
    check("trap_epc", epc, 32'h0000_2004);
    check("trap_irq", {31'h0, irq_enabled}, 32'h0);
    check("trap_vector_kept", trap_vector, 32'h0000_1000);

    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h0000_0088);
    check("mret_irq", {31'h0, irq_enabled}, 32'h1);

    trap = 1'b1; mret = 1'b1; trap_cause = 32'h0000_0003; trap_pc = 32'h0000_4002;
    wr(12'h341, 32'h0000_5550);
    trap = 1'b0; mret = 1'b0;
    rd("all3_mepc", 12'h341, 32'h0000_4000);
    rd("all3_mcause", 12'h342, 32'h0000_0003);
    rd("all3_mstatus", 12'h300, 32'h0000_0080);
    check("all3_epc", epc, 32'h0000_4000);

    mret = 1'b1;
    wr(12'h300, 32'h0000_0000);
    mret = 1'b0;
    rd("mret_over_wr", 12'h300, 32'h0000_0088);

`ifdef CSR_COUNTERS_EN
    trap = 1'b1; trap_cause = 32'h0000_0002; trap_pc = 32'h0000_6001;
    wr(12'hB00, 32'h0000_0100);
    trap = 1'b0;
    rd("cnt_trap_mcycle", 12'hB00, 32'h0000_0100);
    rd("cnt_trap_mepc", 12'h341, 32'h0000_6000);

    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'hFFFF_FFFF);
    rd("pre_wrap_lo", 12'hB00, 32'hFFFF_FFFF);
    rd("pre_wrap_hi", 12'hB80, 32'hFFFF_FFFF);
    rd("pre_wrap_cycleh", 12'hC80, 32'hFFFF_FFFF);
    @(negedge clk);
    rd("wrap_lo", 12'hB00, 32'h0);
    rd("wrap_hi", 12'hB80, 32'h0);
    rd("wrap_cycle", 12'hC00, 32'h0);
    wr(12'hC00, 32'h0000_1234);
    rd("ro_alias_wr", 12'hB00, 32'h1);
`endif

    wr(12'h340, 32'hDEAD_BEEF);
    rd("mscratch_set", 12'h340, 32'hDEAD_BEEF);
    wr(12'h300, 32'h0000_0008);
    check("pre_rst_irq", {31'h0, irq_enabled}, 32'h1);
    rstn = 1'b0;
    #1;
    check("arst_irq", {31'h0, irq_enabled}, 32'h0);
    check("arst_trap_vector", trap_vector, RST_VEC);
    check("arst_epc", epc, 32'h0);
    rd("arst_mscratch", 12'h340, 32'h0);
    rd("arst_mstatus", 12'h300, 32'h0);
    rd("arst_mcause", 12'h342, 32'h0);
    @(negedge clk);
`ifdef CSR_COUNTERS_EN
    rd("arst_mcycle", 12'hB00, 32'h0);
`endif
    rstn = 1'b1;
    rd("post_rst_mepc", 12'h341, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode control/status register file that terminates the CSR write channel leaving the write-back stage and serves the CSR read port used by execute. It holds trap state (mstatus, mtvec, mepc, mcause, mscratch) and the free-running 64-bit cycle and retired-instruction counters. It sits beside the integer register file and is the only owner of CSR state in the core.

## Interface
Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (low 2 bits forced 0)

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous, active-low reset
- r_addr  in  12  CSR read address from execute
- r_data  out  32  read data, combinational from r_addr
- csr_w_enabled  in  1  write strobe from write-back
- csr_w_addr  in  12  write address
- csr_w_data  in  32  write data (already RMW-resolved by execute)
- instr_retired  in  1  one pulse per retired instruction
- trap  in  1  trap entry this cycle
- trap_cause  in  32  mcause value for trap
- trap_pc  in  32  faulting PC
- mret  in  1  mret executed this cycle
- trap_vector  out  32  current mtvec
- epc  out  32  current mepc
- irq_enabled  out  1  mstatus.MIE

## Operation
- Map: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82; read-only aliases cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82; mhartid 0xF14 reads 0.
- mstatus: only MIE (bit 3) and MPIE (bit 7) stored; other bits read 0, writes to them ignored.
- mtvec, mepc: bits [1:0] forced 0 on write and trap.
- Unmapped read returns 0; unmapped or read-only write ignored, no side effects.
- trap: mepc<=trap_pc, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
- mret: MIE<=MPIE, MPIE<=1.
- Per-edge priority: trap > mret > csr_w_enabled for trap-state CSRs. trap and mret together: trap wins, mret dropped.
- Counters: mcycle +1 every cycle; minstret +1 when instr_retired. 64-bit, wrap 0xFFFF_FFFF_FFFF_FFFF -> 0. Write to a half replaces that half with csr_w_data and suppresses that counter's increment that cycle (other half unchanged, no carry).
- Counter write coinciding with trap: both apply (disjoint state).

## Timing
- Writes, trap, mret, counter increments take effect at the rising clk edge; visible on r_data/outputs the next cycle.
- r_data is combinational; read and write of the same address in one cycle returns the old value (no bypass; pipeline forwarding is upstream).
- trap_vector, epc, irq_enabled are register outputs, zero combinational path from inputs.
- Reset (rstn low, any time, async): mtvec=MTVEC_RESET, all other CSRs and counters 0, MIE=MPIE=0; outputs trap_vector=MTVEC_RESET, epc=0, irq_enabled=0, r_data reflects reset state. Release synchronous to clk; first increment on first edge after release.

## Configuration
- CSR_COUNTERS_EN defined: mcycle/minstret and their h/alias addresses implemented as above.
- Undefined: counter addresses read 0, writes ignored, no counter flops; instr_retired unused.

## Structure
- def.sv package: CSR address localparams, mstatus bit indices (MIE=3, MPIE=7), mask constants for mtvec/mepc alignment.
- Sub-module csr_counter64: 64-bit counter with inc, per-half write enable/data, {hi,lo} output; instantiated twice under CSR_COUNTERS_EN.

## Test plan
- Reset with MTVEC_RESET=32'h8000_0100 -> trap_vector=32'h8000_0100, epc=0, read 0x300 = 0, mcycle counts 0,1,2 on consecutive reads after release.
- Write 0x305 = 32'h0000_1003 -> next cycle read 0x305 and trap_vector = 32'h0000_1000; same-cycle read returns old value.
- Write mstatus=0x8, then trap (cause 32'h0000_000B, pc 32'h0000_2006) -> mepc=32'h0000_2004, mcause=0xB, mstatus=0x80; then mret -> mstatus=0x88.
- trap and mret and csr write to 0x341 all same cycle -> mepc=trap_pc, mret ignored, write ignored.
- Write mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF via two writes, then run -> wrap to 0 with 0xB80 reading 0; write to 0xC00 ignored; instret counts only pulsed cycles.
- Assert rstn low mid-run after mscratch=32'hDEAD_BEEF -> all reads 0 immediately, irq_enabled=0.
